// File: rtl/core_if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline stage.
package core_if_id_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // One fetched word: instruction plus the address it came from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } inst_word_t;

    // Per-cycle action for the output slot.
    typedef enum logic [1:0] {
        OUT_HOLD,
        OUT_CLEAR,
        OUT_LOAD_IN,
        OUT_LOAD_SKID
    } out_act_e;

    // Per-cycle action for the skid slot.
    typedef enum logic [1:0] {
        SKID_HOLD,
        SKID_CLEAR,
        SKID_LOAD
    } skid_act_e;

endpackage

// File: rtl/core_if_id_if.sv
// Fetch-side handshake and decode-side signals of the IF/ID stage.
interface core_if_id_if;
    logic [31:0] inst_in;
    logic [31:0] inst_addr_in;
    logic        inst_valid_in;
    logic        inst_ready_out;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;
    logic        inst_valid_out;

    // The pipeline stage itself.
    modport slave (
        input  inst_in, inst_addr_in, inst_valid_in, stall_in, flush_in,
        output inst_ready_out, inst_out, inst_addr_out, inst_valid_out
    );

    // Fetch / decode environment around the stage.
    modport master (
        output inst_in, inst_addr_in, inst_valid_in, stall_in, flush_in,
        input  inst_ready_out, inst_out, inst_addr_out, inst_valid_out
    );
endinterface

// File: rtl/core_if_id_pipe_slot.sv
// One {valid, inst, addr} register with load and clear; clear and reset
// put the bubble word back so an empty slot always presents a NOP.
module core_pipe_slot
    import core_if_id_pkg::*;
#(
    parameter logic [31:0] CLEAR_INST = INST_NOP,
    parameter logic [31:0] CLEAR_ADDR = ZERO_WORD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  inst_word_t word_in,
    output logic       valid,
    output inst_word_t word
);

    // Clear beats load so a flush can never leave a word behind.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid     <= 1'b0;
            word.inst <= CLEAR_INST;
            word.addr <= CLEAR_ADDR;
        end else if (load) begin
            valid <= 1'b1;
            word  <= word_in;
        end
    end

endmodule

// File: rtl/core_if_id.sv
// IF/ID stage: output slot feeding decode plus a one-entry skid slot that
// catches the word accepted in the same cycle decode starts stalling.
module core_if_id
    import core_if_id_pkg::*;
#(
    parameter logic [31:0] NOP_INST    = INST_NOP,
    parameter logic [31:0] BUBBLE_ADDR = ZERO_WORD
) (
    input logic         clk,
    input logic         rst,
    core_if_id_if.slave bus
);

    logic       out_valid;
    logic       skid_valid;
    inst_word_t out_word;
    inst_word_t skid_word;
    inst_word_t in_word;
    inst_word_t out_next;
    logic       acc;
    out_act_e   out_act;
    skid_act_e  skid_act;

    assign in_word.inst = bus.inst_in;
    assign in_word.addr = bus.inst_addr_in;

    // Ready comes straight off the skid valid flop: a full skid is the only
    // condition that blocks fetch, so no combinational path from stall.
    assign bus.inst_ready_out = !skid_valid;
    assign acc = bus.inst_valid_in && bus.inst_ready_out;

    // Slot actions, highest priority first: flush, drain skid, pass-through,
    // bubble collapse under stall, catch into skid under stall.
    always_comb begin
        out_act  = OUT_HOLD;
        skid_act = SKID_HOLD;
        if (bus.flush_in) begin
            out_act  = OUT_CLEAR;
            skid_act = SKID_CLEAR;
        end else if (!bus.stall_in) begin
            if (skid_valid) begin
                out_act  = OUT_LOAD_SKID;
                skid_act = SKID_CLEAR;
            end else if (acc) begin
                out_act = OUT_LOAD_IN;
            end else begin
                out_act = OUT_CLEAR;
            end
        end else if (!out_valid) begin
            if (acc) out_act = OUT_LOAD_IN;
        end else if (acc) begin
            skid_act = SKID_LOAD;
        end
    end

    // Output slot source: the skid word when draining, else the fetch word.
    always_comb begin
        out_next = (out_act == OUT_LOAD_SKID) ? skid_word : in_word;
    end

    core_pipe_slot #(
        .CLEAR_INST (NOP_INST),
        .CLEAR_ADDR (BUBBLE_ADDR)
    ) u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .load    ((out_act == OUT_LOAD_IN) || (out_act == OUT_LOAD_SKID)),
        .clear   (out_act == OUT_CLEAR),
        .word_in (out_next),
        .valid   (out_valid),
        .word    (out_word)
    );

    core_pipe_slot #(
        .CLEAR_INST (NOP_INST),
        .CLEAR_ADDR (BUBBLE_ADDR)
    ) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_act == SKID_LOAD),
        .clear   (skid_act == SKID_CLEAR),
        .word_in (in_word),
        .valid   (skid_valid),
        .word    (skid_word)
    );

    assign bus.inst_valid_out = out_valid;
    assign bus.inst_out       = out_word.inst;
    assign bus.inst_addr_out  = out_word.addr;

endmodule
